// File: rtl/alu_stream_pkg.sv
// Shared types for the ALU stream engine: opcodes, FSM states and command field widths.
package alu_stream_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WRITE
  } fsm_e;

endpackage

// File: rtl/alu_stream_engine_fifo.sv
// Count-based synchronous FIFO with show-ahead head data; pushes when full and pops when empty are ignored.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop  && (count != '0);
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_stream_engine.sv
// Streaming ALU: input FIFO -> IDLE/EXEC/WRITE FSM -> output FIFO.
// Define ALU_DIV0_ERR_EN to add the sticky div0_err output.
module alu_stream_engine
  import alu_stream_pkg::*;
#(
  parameter int W         = 4,
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 8,
  parameter int MUL_CYC   = 3,
  parameter int DIV_CYC   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*W+OP_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*W-1:0]    out_data,
  output logic              busy
`ifdef ALU_DIV0_ERR_EN
  ,
  output logic              div0_err
`endif
);

  localparam int RW      = 2 * W;
  localparam int DW      = 2 * W + OP_W;
  localparam int ICW     = $clog2(IN_DEPTH) + 1;
  localparam int OCW     = $clog2(OUT_DEPTH) + 1;
  localparam int MAX_CYC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [ICW-1:0]   IN_FULL_CNT  = ICW'(IN_DEPTH);
  localparam logic [OCW-1:0]   OUT_FULL_CNT = OCW'(OUT_DEPTH);
  localparam logic [CNT_W-1:0] MUL_LAST     = CNT_W'(MUL_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LAST     = CNT_W'(DIV_CYC - 1);

  logic [DW-1:0]    in_head;
  logic [ICW-1:0]   in_count;
  logic [OCW-1:0]   out_count;
  logic             in_pop;
  logic             out_push;

  fsm_e             state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     a_q, b_q;
  op_e              op_q;
  logic [RW-1:0]    result_q;

  logic [W-1:0]     head_a, head_b;
  op_e              head_op;
  logic [RW-1:0]    addsub_res;
  logic [RW-1:0]    muldiv_res;
  logic [CNT_W-1:0] exec_last;

  assign in_ready  = (in_count != IN_FULL_CNT);
  assign out_valid = (out_count != '0);
  assign busy      = (state_q != S_IDLE);

  stream_fifo #(.WIDTH(DW), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid && in_ready),
    .pop   (in_pop),
    .wdata (in_data),
    .rdata (in_head),
    .count (in_count)
  );

  stream_fifo #(.WIDTH(RW), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (out_push),
    .pop   (out_valid && out_ready),
    .wdata (result_q),
    .rdata (out_data),
    .count (out_count)
  );

  assign head_a  = in_head[W-1:0];
  assign head_b  = in_head[2*W-1:W];
  assign head_op = op_e'(in_head[DW-1 -: OP_W]);

  // ADD/SUB resolve straight from the FIFO head; MUL/DIV use the latched operands.
  assign addsub_res = (head_op == OP_SUB) ? RW'(head_a) - RW'(head_b)
                                          : RW'(head_a) + RW'(head_b);
  assign muldiv_res = (op_q == OP_MUL) ? RW'(a_q) * RW'(b_q)
                    : (b_q == '0)      ? '1
                                       : RW'(a_q) / RW'(b_q);
  assign exec_last  = (op_q == OP_MUL) ? MUL_LAST : DIV_LAST;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    in_pop   = 1'b0;
    out_push = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // In IDLE nothing is in flight, so one free output slot is enough to start.
        if (in_count != '0 && out_count != OUT_FULL_CNT) begin
          in_pop  = 1'b1;
          state_d = (head_op == OP_ADD || head_op == OP_SUB) ? S_WRITE : S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == exec_last) state_d = S_WRITE;
      end
      S_WRITE: begin
        out_push = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (in_pop) begin
            a_q      <= head_a;
            b_q      <= head_b;
            op_q     <= head_op;
            cnt_q    <= '0;
            result_q <= addsub_res;
          end
        end
        S_EXEC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == exec_last) result_q <= muldiv_res;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_DIV0_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div0_err <= 1'b0;
    end else if (state_q == S_WRITE && op_q == OP_DIV && b_q == '0) begin
      div0_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_stream_engine.sv
// Directed self-checking bench for alu_stream_engine at default parameters (W=4, depths 8, 3-cycle MUL/DIV).
module tb_alu_stream_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
`ifdef ALU_DIV0_ERR_EN
  logic       div0_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];

  alu_stream_engine dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef ALU_DIV0_ERR_EN
    ,
    .div0_err  (div0_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [9:0] cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    return {op, b, a};
  endfunction

  // Called at a negedge; holds in_valid until the word is accepted (bounded).
  task automatic send(input logic [9:0] d, output bit ok);
    ok       = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Edge count from the accepting edge until out_valid is seen.
  task automatic latency(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    if (!out_valid) check({tag, "_timeout"}, 32'(out_valid), 32'd1);
    else            check(tag, 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    bit ok;
    int lat;
    int accepted;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
`ifdef ALU_DIV0_ERR_EN
    check("rst_div0",      32'(div0_err),  32'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic ops and latencies
    send(cmd(2'd0, 4'd3, 4'd4), ok);
    latency(lat);
    check("add_lat", 32'(lat), 32'd3);
    pop_check("add_3_4", 8'd7);

    send(cmd(2'd1, 4'd2, 4'd5), ok);
    latency(lat);
    check("sub_lat", 32'(lat), 32'd3);
    pop_check("sub_2_5", 8'hFD);

    send(cmd(2'd2, 4'd15, 4'd15), ok);
    latency(lat);
    check("mul_lat", 32'(lat), 32'd6);
    pop_check("mul_15_15", 8'd225);

    send(cmd(2'd3, 4'd9, 4'd3), ok);
    latency(lat);
    check("div_lat", 32'(lat), 32'd6);
    pop_check("div_9_3", 8'd3);

    send(cmd(2'd3, 4'd9, 4'd0), ok);
    pop_check("div_9_0", 8'hFF);
`ifdef ALU_DIV0_ERR_EN
    check("div0_set", 32'(div0_err), 32'd1);
`endif
    send(cmd(2'd0, 4'd1, 4'd0), ok);
    pop_check("add_after_div0", 8'd1);
`ifdef ALU_DIV0_ERR_EN
    check("div0_sticky", 32'(div0_err), 32'd1);
`endif

    // Back-to-back pushes at empty input FIFO: push+pop keeps count at 1
    in_data  = cmd(2'd0, 4'd1, 4'd1);
    in_valid = 1'b1;
    @(negedge clk);
    check("in_cnt_first_push", 32'(dut.u_in_fifo.count), 32'd1);
    in_data = cmd(2'd0, 4'd2, 4'd2);
    @(negedge clk);
    check("in_cnt_push_pop", 32'(dut.u_in_fifo.count), 32'd1);
    in_valid = 1'b0;
    pop_check("b2b_first", 8'd2);
    pop_check("b2b_second", 8'd4);

    // Back-pressure: 20 ADDs with the consumer stalled
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      logic [3:0] a, b;
      a = 4'(i);
      b = 4'(i * 3);
      send(cmd(2'd0, a, b), ok);
      if (ok) begin
        accepted++;
        exp_q.push_back(8'(a) + 8'(b));
      end
    end
    check("bp_accepted", 32'(accepted), 32'd16);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_in_cnt",   32'(dut.u_in_fifo.count), 32'd8);

    // Input full, in_valid held, one output pop frees a slot so the FSM pops input
    in_data   = cmd(2'd0, 4'd15, 4'd14);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check("full_head", 32'(out_data), 32'(exp_q.pop_front()));
    @(negedge clk);
    out_ready = 1'b0;
    check("full_still_full", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("fsm_pop_no_push", 32'(dut.u_in_fifo.count), 32'd7);
    check("fsm_pop_ready",   32'(in_ready), 32'd1);
    @(negedge clk);
    check("refill_cnt", 32'(dut.u_in_fifo.count), 32'd8);
    in_valid = 1'b0;
    exp_q.push_back(8'd29);
    check("drain_len", 32'(exp_q.size()), 32'd16);
    while (exp_q.size() > 0) pop_check("drain", exp_q.pop_front());
    repeat (2) @(negedge clk);
    check("drain_empty", 32'(out_valid), 32'd0);

    // Reset during MUL EXEC with queued input and a pending output word
    send(cmd(2'd0, 4'd7, 4'd7), ok);
    repeat (3) @(negedge clk);
    send(cmd(2'd2, 4'd5, 4'd6), ok);
    send(cmd(2'd0, 4'd1, 4'd2), ok);
    send(cmd(2'd0, 4'd3, 4'd3), ok);
    check("pre_rst_busy",  32'(busy),      32'd1);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_busy",      32'(busy),      32'd0);
    check("midrst_in_cnt",    32'(dut.u_in_fifo.count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`ifdef ALU_DIV0_ERR_EN
    check("div0_cleared", 32'(div0_err), 32'd0);
`endif
    send(cmd(2'd0, 4'd3, 4'd4), ok);
    latency(lat);
    check("post_rst_lat", 32'(lat), 32'd3);
    pop_check("post_rst_add", 8'd7);
    repeat (2) @(negedge clk);
    check("post_rst_empty", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
